imem_loader: RTL and testbench

- Instruction-memory responder for the single-cycle CPU. It answers the fetch interface combinationally: PC in, instr out.
- At reset it fills its word array from a byte stream on a valid/ready port, holding the CPU in reset while it loads.
- Once the image is complete it releases the CPU and serves fetches from the array.
- It sits between the board-level loader source (UART/testbench) and the CPU's instr/PC/rst pins.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_array.sv | 27 ++
 rtl/imem_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// the fetch filler word and the depth-to-address-width helper.
package imem_loader_pkg;

  // Loader FSM encoding. The values are fixed so that debug taps and
  // external tooling can decode the state bits directly.
  typedef enum logic [1:0] {
    S_LEN  = 2'd0,  // collecting the 4-byte big-endian word count
    S_LOAD = 2'd1,  // collecting image words, 4 bytes each
    S_RUN  = 2'd2,  // image complete, CPU released
    S_ERR  = 2'd3   // header asked for more words than the array holds
  } state_t;

  // Returned on the fetch port whenever the array must not be exposed.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Word-address width needed to index a DEPTH_WORDS-entry array.
  function automatic int addr_w_for(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset so that a
// short reload leaves the upper words of a previous image in place.
module imem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Word write; a word written on one edge is readable from the next cycle.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory responder for the single-cycle CPU. After reset it
// pulls a length-prefixed big-endian image from a byte stream into the
// word array while holding the CPU in reset, then releases the CPU and
// answers fetches combinationally.
//
// Loader handshake: a byte is transferred on every rising edge where
// ld_valid && ld_ready. ld_ready depends only on the state register, so it
// never depends on ld_valid in the same cycle, and ld_valid while ld_ready
// is low has no effect at all.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = addr_w_for(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  input  logic [31:0]       PC,
  output logic [31:0]       instr,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  output state_t            o_dbg_state
);

  localparam logic [31:0] LP_DEPTH = 32'(DEPTH_WORDS);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_byte_cnt;
  logic [1:0]          w_byte_cnt_nxt;
  logic [31:0]         r_len;
  logic [31:0]         w_len_nxt;
  logic [23:0]         r_word;
  logic [23:0]         w_word_nxt;
  logic [ADDR_W-1:0]   r_waddr;
  logic [ADDR_W-1:0]   w_waddr_nxt;
  logic [ADDR_W:0]     r_words_loaded;
  logic [ADDR_W:0]     w_words_loaded_nxt;

  logic                w_accept;
  logic [31:0]         w_len_full;
  logic [31:0]         w_word_full;
  logic                w_last_word;
  logic                w_we;
  logic [31:0]         w_rdata;
  logic                w_pc_in_range;
  logic                w_unused_pc;

  // Handshake and status outputs are pure state decodes.
  assign ld_ready     = (r_state == S_LEN) || (r_state == S_LOAD);
  assign cpu_rst      = (r_state != S_RUN);
  assign done         = (r_state == S_RUN);
  assign err          = (r_state == S_ERR);
  assign words_loaded = r_words_loaded;
  assign o_dbg_state  = r_state;

  assign w_accept    = ld_valid && ld_ready;
  // Header and data words are assembled MSB first; the current byte is
  // the least significant one, so the 4th byte completes the value.
  assign w_len_full  = {r_len[23:0], ld_byte};
  assign w_word_full = {r_word, ld_byte};
  // words_loaded equals the write address while loading but, unlike the
  // address, does not wrap when the image fills the whole array.
  assign w_last_word = ({{(31-ADDR_W){1'b0}}, r_words_loaded} + 32'd1) == r_len;

  // Next-state, byte assembly and write-enable decode for the loader FSM.
  always_comb begin
    w_state_nxt        = r_state;
    w_byte_cnt_nxt     = r_byte_cnt;
    w_len_nxt          = r_len;
    w_word_nxt         = r_word;
    w_waddr_nxt        = r_waddr;
    w_words_loaded_nxt = r_words_loaded;
    w_we               = 1'b0;
    case (r_state)
      S_LEN: begin
        if (w_accept) begin
          w_len_nxt      = w_len_full;
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_waddr_nxt        = '0;
            w_words_loaded_nxt = '0;
            if (w_len_full == 32'd0) begin
              w_state_nxt = S_RUN;
            end else if (w_len_full > LP_DEPTH) begin
              w_state_nxt = S_ERR;
            end else begin
              w_state_nxt = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_word_nxt     = w_word_full[23:0];
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_we               = 1'b1;
            w_waddr_nxt        = r_waddr + ADDR_W'(1);
            w_words_loaded_nxt = r_words_loaded + (ADDR_W+1)'(1);
            if (w_last_word) begin
              w_state_nxt = S_RUN;
            end
          end
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_LEN;
      end
    endcase
  end

  // Loader state registers; reset discards any partially assembled word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_LEN;
      r_byte_cnt     <= 2'd0;
      r_len          <= 32'd0;
      r_word         <= 24'd0;
      r_waddr        <= '0;
      r_words_loaded <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_byte_cnt     <= w_byte_cnt_nxt;
      r_len          <= w_len_nxt;
      r_word         <= w_word_nxt;
      r_waddr        <= w_waddr_nxt;
      r_words_loaded <= w_words_loaded_nxt;
    end
  end

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_waddr),
    .i_wdata (w_word_full),
    .i_raddr (PC[ADDR_W+1:2]),
    .o_rdata (w_rdata)
  );

  // Fetch masking: PC is a byte address, the low two bits select a byte
  // within the word and are irrelevant to a word fetch.
  assign w_unused_pc   = ^PC[1:0];
  assign w_pc_in_range = (PC[31:ADDR_W+2] == '0);
  assign instr         = ((r_state == S_RUN) && w_pc_in_range) ? w_rdata : NOP;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed image streams with a queue of expected
// fetch words, checked by fetching after each load completes.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic [31:0] PC;
  logic [31:0] instr;
  logic        cpu_rst;
  logic        done;
  logic        err;
  logic [10:0] words_loaded;
  state_t      dbg_state;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic [31:0] word_1023;

  imem_loader #(
    .DEPTH_WORDS (1024),
    .ADDR_W      (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_ready     (ld_ready),
    .PC           (PC),
    .instr        (instr),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .o_dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    ld_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_byte  = b;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    do_reset(2);
    PC = 32'h0;
    #1;
    n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
    n_vec++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_vec++; if (words_loaded !== 11'd0) begin n_err++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_vec++; if (dbg_state !== S_LEN) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_LEN); end
  endtask

  task automatic test_basic_load;
    logic [7:0] img [12] = '{8'h00, 8'h00, 8'h00, 8'h02,
                             8'h20, 8'h08, 8'h00, 8'h05,
                             8'h01, 8'h09, 8'h50, 8'h20};
    logic [31:0] pcs [3] = '{32'd0, 32'd4, 32'd6};
    exp_q.push_back(32'h2008_0005);
    exp_q.push_back(32'h0109_5020);
    exp_q.push_back(32'h0109_5020);
    for (int i = 0; i < 12; i++) begin
      ld_valid = 1'b1;
      ld_byte  = img[i];
      #1;
      n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready byte %0d: got %b want 1", i, ld_ready); end
      n_vec++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL basic_cpu_rst byte %0d: got %b want 1", i, cpu_rst); end
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", done); end
    n_vec++; if (cpu_rst !== 1'b0) begin n_err++; $display("FAIL basic_cpu_rst_end: got %b want 0", cpu_rst); end
    n_vec++; if (words_loaded !== 11'd2) begin n_err++; $display("FAIL basic_words: got %0d want 2", words_loaded); end
    for (int i = 0; i < 3; i++) begin
      PC = pcs[i];
      #1;
      exp_w = exp_q.pop_front();
      n_vec++; if (instr !== exp_w) begin n_err++; $display("FAIL basic_fetch pc=%h: got %h want %h", PC, instr, exp_w); end
    end
  endtask

  task automatic test_zero_length;
    do_reset(1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_early: got %b want 0", done); end
    send_byte(8'h00);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", done); end
    n_vec++; if (words_loaded !== 11'd0) begin n_err++; $display("FAIL zero_words: got %0d want 0", words_loaded); end
    n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL zero_ready: got %b want 0", ld_ready); end
    n_vec++; if (cpu_rst !== 1'b0) begin n_err++; $display("FAIL zero_cpu_rst: got %b want 0", cpu_rst); end
    // Reset does not clear the array: the previous image is still there.
    exp_q.push_back(32'h2008_0005);
    PC = 32'h0;
    #1;
    exp_w = exp_q.pop_front();
    n_vec++; if (instr !== exp_w) begin n_err++; $display("FAIL zero_keep_mem: got %h want %h", instr, exp_w); end
  endtask

  task automatic test_oversize;
    do_reset(1);
    send_word(32'h0000_0401);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL over_err: got %b want 1", err); end
    n_vec++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL over_cpu_rst: got %b want 1", cpu_rst); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL over_done: got %b want 0", done); end
    n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL over_ready: got %b want 0", ld_ready); end
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
    PC = 32'h0;
    #1;
    n_vec++; if (dbg_state !== S_ERR) begin n_err++; $display("FAIL over_stuck: got %0d want %0d", dbg_state, S_ERR); end
    n_vec++; if (words_loaded !== 11'd0) begin n_err++; $display("FAIL over_words: got %0d want 0", words_loaded); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL over_instr: got %h want 0", instr); end
  endtask

  task automatic test_full_depth;
    logic [31:0] w;
    do_reset(1);
    send_word(32'h0000_0400);
    n_vec++; if (dbg_state !== S_LOAD) begin n_err++; $display("FAIL full_accept_hdr: got %0d want %0d", dbg_state, S_LOAD); end
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      exp_q.push_back(w);
      if (i == 1023) word_1023 = w;
      send_word(w);
      if (i == 1022) begin
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL full_done_early: got %b want 0", done); end
      end
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL full_done: got %b want 1", done); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL full_err: got %b want 0", err); end
    n_vec++; if (words_loaded !== 11'd1024) begin n_err++; $display("FAIL full_words: got %0d want 1024", words_loaded); end
    for (int i = 0; i < 1024; i++) begin
      PC = (i * 4) + $urandom_range(0, 3);
      #1;
      exp_w = exp_q.pop_front();
      n_vec++; if (instr !== exp_w) begin n_err++; $display("FAIL full_fetch pc=%h: got %h want %h", PC, instr, exp_w); end
    end
  endtask

  task automatic test_gapped;
    logic [7:0] img [12] = '{8'h00, 8'h00, 8'h00, 8'h02,
                             8'h20, 8'h08, 8'h00, 8'h05,
                             8'h01, 8'h09, 8'h50, 8'h20};
    do_reset(1);
    exp_q.push_back(32'h2008_0005);
    exp_q.push_back(32'h0109_5020);
    for (int i = 0; i < 12; i++) begin
      send_byte(img[i]);
      n_vec++; if (done !== (i == 11)) begin n_err++; $display("FAIL gap_done byte %0d: got %b want %b", i, done, (i == 11)); end
      n_vec++; if (words_loaded !== 11'((i + 1 - 4) / 4 + ((i >= 3) ? 0 : 0)) && i >= 3)
        begin n_err++; $display("FAIL gap_words byte %0d: got %0d want %0d", i, words_loaded, (i - 3) / 4); end
      if (i < 11) begin
        ld_valid = 1'b0;
        ld_byte  = 8'($urandom_range(0, 255));
        PC       = 32'h0;
        @(posedge clk);
        #1;
        n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL gap_instr_predone byte %0d: got %h want 0", i, instr); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      PC = i * 4;
      #1;
      exp_w = exp_q.pop_front();
      n_vec++; if (instr !== exp_w) begin n_err++; $display("FAIL gap_fetch pc=%h: got %h want %h", PC, instr, exp_w); end
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] pcs [4] = '{32'h0000_1000, 32'h0000_1004, 32'hFFFF_FFFC, 32'h0000_0FFC};
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(word_1023);
    for (int i = 0; i < 4; i++) begin
      PC = pcs[i];
      #1;
      exp_w = exp_q.pop_front();
      n_vec++; if (instr !== exp_w) begin n_err++; $display("FAIL oor_fetch pc=%h: got %h want %h", PC, instr, exp_w); end
    end
  endtask

  task automatic test_reset_mid_load;
    do_reset(1);
    send_word(32'h0000_0002);
    send_byte(8'h11);
    send_byte(8'h22);
    // Reset coincides with an offered byte; reset must win.
    rst      = 1'b1;
    ld_valid = 1'b1;
    ld_byte  = 8'h33;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ld_valid = 1'b0;
    n_vec++; if (dbg_state !== S_LEN) begin n_err++; $display("FAIL rml_state: got %0d want %0d", dbg_state, S_LEN); end
    n_vec++; if (words_loaded !== 11'd0) begin n_err++; $display("FAIL rml_words_rst: got %0d want 0", words_loaded); end
    n_vec++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL rml_cpu_rst: got %b want 1", cpu_rst); end
    send_word(32'h0000_0001);
    send_word(32'hDEAD_BEEF);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL rml_done: got %b want 1", done); end
    n_vec++; if (words_loaded !== 11'd1) begin n_err++; $display("FAIL rml_words: got %0d want 1", words_loaded); end
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h0109_5020);
    for (int i = 0; i < 2; i++) begin
      PC = i * 4;
      #1;
      exp_w = exp_q.pop_front();
      n_vec++; if (instr !== exp_w) begin n_err++; $display("FAIL rml_fetch pc=%h: got %h want %h", PC, instr, exp_w); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    ld_valid = 1'b0;
    ld_byte  = 8'h00;
    PC       = 32'h0;
    word_1023 = 32'h0;
    test_reset();
    test_basic_load();
    test_zero_length();
    test_oversize();
    test_full_depth();
    test_gapped();
    test_out_of_range();
    test_reset_mid_load();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
